// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receiver state encoding and vote helper
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte output handshake and status flags of the UART receiver
interface uart_rx_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] data_out;
  logic data_valid;
  logic data_ready;
  logic frame_err;
  logic overrun;
  logic busy;
  modport master(output data_out, data_valid, frame_err, overrun, busy, input data_ready);
  modport slave(input data_out, data_valid, frame_err, overrun, busy, output data_ready);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: N-stage synchroniser for asynchronous inputs with a selectable reset value
module sync_ff #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [N-1:0][W-1:0] chain;
  always_ff @(posedge clk or posedge rst)
    if (rst) chain <= {N{rst_val}};
    else chain <= {chain[N-2:0], d};
  assign q = chain[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with majority-voted sampling and a one-deep valid/ready holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] M = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_t state;
  logic rx_s, s_a, s_b, vote, at_smp;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] sr;
  sync_ff #(.N(SYNC_STAGES), .W(1)) u_sync (
    .clk(clk), .rst(rst), .rst_val(1'b1), .d(rx), .q(rx_s)
  );
  assign vote = maj3(s_a, s_b, rx_s);
  assign at_smp = cnt == M + 1'b1;
  // the counter free-runs across bits so each sample lands mid-bit relative to the start edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sr <= '0;
      s_a <= 1'b1;
      s_b <= 1'b1;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (cnt == M - 1'b1) s_a <= rx_s;
      if (cnt == M) s_b <= rx_s;
      if (bus.data_ready) bus.data_valid <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            cnt <= '0;
            bus.busy <= 1'b1;
          end
        START:
          if (at_smp) begin
            state <= vote ? IDLE : DATA;
            bus.busy <= !vote;
            bit_idx <= '0;
          end
        DATA:
          if (at_smp) begin
            sr <= {vote, sr[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BW'(DATA_BITS - 1)) state <= STOP;
          end
        STOP:
          if (at_smp) begin
            if (vote) begin
              bus.data_out <= sr;
              bus.data_valid <= 1'b1;
              bus.overrun <= bus.data_valid & !bus.data_ready;
              state <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              bus.frame_err <= 1'b1;
              state <= BREAK;
            end
          end
        BREAK:
          if (rx_s) begin
            state <= IDLE;
            bus.busy <= 1'b0;
          end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a byte-level model of the receiver
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int M = CPB / 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  uart_rx_if bus();
  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  int fe_cycles = 0, fe_pulses = 0, ov_cycles = 0, ov_pulses = 0;
  int dv_cycles = 0, dv_rises = 0, rise_cyc = -1;
  logic fe_q = 1'b0, ov_q = 1'b0, dv_q = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  int ov_exp = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    #1;
    if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) got.push_back(bus.data_out);
    if (bus.frame_err === 1'b1) fe_cycles++;
    if (bus.frame_err === 1'b1 && !fe_q) fe_pulses++;
    if (bus.overrun === 1'b1) ov_cycles++;
    if (bus.overrun === 1'b1 && !ov_q) ov_pulses++;
    if (bus.data_valid === 1'b1) dv_cycles++;
    if (bus.data_valid === 1'b1 && !dv_q) begin
      dv_rises++;
      rise_cyc = cyc;
    end
    fe_q = bus.frame_err === 1'b1;
    ov_q = bus.overrun === 1'b1;
    dv_q = bus.data_valid === 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask
  // glitch flips the line for one cycle at the middle of every bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++)
      if (glitch) begin
        drive(f[i], M);
        drive(~f[i], 1);
        drive(f[i], CPB - M - 1);
      end else drive(f[i], CPB);
    rx = 1'b1;
  endtask
  task automatic deliver(input logic [7:0] d);
    if (bus.data_ready) exp_q.push_back(d);
    else begin
      if (hold_v) ov_exp++;
      hold_d = d;
      hold_v = 1'b1;
    end
  endtask
  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
  endtask
  initial begin
    int c0, n, gap;
    logic [7:0] b;
    bit g;
    bus.data_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    deliver(8'hA5);
    drive(1'b1, CPB);
    cmp_stream("a5");
    chk("a5_dv_cycles", dv_cycles, 1);
    chk("a5_latency_ok", (rise_cyc - c0 >= 150) && (rise_cyc - c0 <= 164), 1);
    chk("a5_busy_idle", bus.busy, 0);
    chk("a5_fe", fe_pulses, 0);
    chk("a5_ov", ov_pulses, 0);
    send_frame(8'h00, 1'b1, 1'b0);
    deliver(8'h00);
    send_frame(8'hFF, 1'b1, 1'b0);
    deliver(8'hFF);
    drive(1'b1, CPB);
    cmp_stream("b2b");
    chk("b2b_fe", fe_pulses, 0);
    n = dv_rises;
    drive(1'b0, 5);
    drive(1'b1, 3 * CPB);
    chk("glitch_no_valid", dv_rises, n);
    chk("glitch_busy", bus.busy, 0);
    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 2 * CPB);
    chk("fe_pulses", fe_pulses, 1);
    chk("fe_width", fe_cycles, 1);
    chk("fe_busy", bus.busy, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    deliver(8'h81);
    drive(1'b1, CPB);
    cmp_stream("after_fe");
    bus.data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    deliver(8'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    deliver(8'h22);
    drive(1'b1, CPB);
    chk("ov_pulses", ov_pulses, ov_exp);
    chk("ov_width", ov_cycles, ov_exp);
    chk("ov_valid", bus.data_valid, 1);
    chk("ov_data", bus.data_out, hold_d);
    bus.data_ready = 1'b1;
    exp_q.push_back(hold_d);
    hold_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ov_drained", bus.data_valid, 0);
    cmp_stream("ov");
    bus.data_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1);
    deliver(8'h5A);
    drive(1'b1, CPB);
    chk("vote_valid", bus.data_valid, 1);
    chk("vote_data", bus.data_out, hold_d);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, M);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_valid", bus.data_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_fe", bus.frame_err, 0);
    hold_v = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0);
    deliver(8'hC3);
    drive(1'b1, CPB);
    cmp_stream("post_rst");
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      g = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 20);
      send_frame(b, 1'b1, g);
      deliver(b);
      drive(1'b1, gap);
    end
    drive(1'b1, 2 * CPB);
    cmp_stream("rand");
    chk("final_fe", fe_pulses, 1);
    chk("final_ov", ov_pulses, ov_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that complements the existing uart_tx; same bit timing, LSB first.
- Sits between a top-level input pin and on-chip consumers, e.g. a loopback/command path beside the ring-oscillator RNG stream.
- Synchronises the asynchronous rx line, validates start and stop bits with 3-sample majority voting, and presents each byte through a one-deep valid/ready holding register.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, default 434, clk cycles per bit (e.g. 50 MHz / 115200); legal range >= 8.
- SYNC_STAGES, default 2, rx synchroniser depth; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  received byte, valid while data_valid=1.
- data_valid  output  1  holding register full.
- data_ready  input  1  consumer accepts the byte when data_valid and data_ready are both 1.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: a new byte overwrote an unconsumed byte.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert by the clk domain):
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE.
  - Synchroniser flops preset to 1 so reset does not fake a start bit.
- Synchroniser: rx_s = rx delayed by SYNC_STAGES flops. All FSM decisions use rx_s.
- Bit counter: counts 0..CLKS_PER_BIT-1. Mid-bit index is M = CLKS_PER_BIT/2 (integer division).
- Sample: majority of rx_s at counter M-1, M and M+1, evaluated at M+1.
- IDLE:
  - rx_s=0 → START, counter cleared to 0.
  - Otherwise stay in IDLE.
- START:
  - At the start-bit sample point, vote=1 → false start: return to IDLE, no outputs change.
  - Vote=0 → DATA, bit index 0. The counter continues so that later samples land mid-bit.
- DATA:
  - At each sample point, shift the vote into the shift register, LSB first.
  - After bit 7 → STOP.
- STOP:
  - At the sample point, vote=1 → load data_out, set data_valid, go to IDLE. IDLE may detect the next start immediately, so back-to-back frames are supported.
  - Vote=0 → frame_err pulse for 1 cycle, byte discarded, go to BREAK.
- BREAK: wait for rx_s=1, then IDLE. This prevents a held-low line from retriggering.
- Latency: data_valid rises on the cycle after the stop-bit sample point, i.e. about 9.5 bit times + SYNC_STAGES + 2 cycles after the rx falling edge.
- Handshake:
  - data_valid stays high until a cycle with data_ready=1. On that cycle's edge, data_valid clears (unless a load coincides).
  - data_out is stable while data_valid=1, except on an overrun.
  - data_ready while data_valid=0 is ignored.
- Simultaneous load and accept (data_ready=1 in the same cycle a new byte loads): old byte consumed, new byte loaded, data_valid stays 1, no overrun.
- Load while data_valid=1 and data_ready=0: data_out overwritten with the new byte, data_valid stays 1, overrun pulses 1 cycle.
- Reset mid-frame: immediate return to the reset state; partial byte lost; no error pulse.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - DATA_BITS=8.
  - Default CLKS_PER_BIT, shared with uart_tx so both ends agree on baud.
- One natural sub-module: sync_ff.
  - Parameterised N-stage synchroniser with a reset value input.
  - Reusable for other async pins such as ui_in.
- The bit counter and FSM stay inline.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, data_ready=1 unless stated):
- Reset, then byte 0xA5 sent 8N1 → single data_valid cycle with data_out=0xA5; frame_err=0, overrun=0; busy falls back to 0.
- 0x00 then 0xFF back-to-back, no idle gap → two accepts, 0x00 then 0xFF, no errors.
- rx low pulse of 5 cycles then high (glitch) → FSM returns to IDLE; data_valid never set.
- 0x3C with stop bit forced 0, then rx held low for 40 cycles, then high, then 0x81 → frame_err single pulse; no data_valid for 0x3C; 0x81 received correctly afterwards.
- data_ready=0, send 0x11 then 0x22 → data_out=0x22 with one overrun pulse; raising data_ready consumes 0x22 and clears data_valid.
- One-cycle glitch injected at each bit's mid-point (sample M) on 0x5A → majority vote still yields 0x5A; rst asserted mid-byte → all outputs 0 asynchronously, next clean frame received correctly.
